program_loader: RTL
===================

PROGRAM_LOADER -- requirements
Module: program_loader

Interface
REQ-001 Parameter DEPTH, default 16, SHALL set the number of RAM words the loader can write.
REQ-002 Parameter ADDR_W, default 11, SHALL set the MAR address width.
REQ-003 Parameter DATA_W, default 16, SHALL set the bus and word width.
REQ-004 clock  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-005 reset_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-006 start  input  1  SHALL request a load session; sampled only in IDLE.
REQ-007 load_len  input  $clog2(DEPTH)+1  SHALL give the word count to load (0..DEPTH); captured with start.
REQ-008 abort  input  1  SHALL terminate a session.
REQ-009 word_valid  input  1  SHALL mark word_data as valid (host side).
REQ-010 word_data  input  DATA_W  SHALL carry the next program/data word.
REQ-011 word_ready  output  1  SHALL indicate the loader accepts a word this cycle.
REQ-012 bus_out  output  DATA_W  SHALL drive the shared data bus; all-Z when bus_oe=0.
REQ-013 bus_oe  output  1  SHALL indicate the loader owns the bus.
REQ-014 mar_le  output  1  SHALL be the MAR load enable.
REQ-015 ram_le  output  1  SHALL be the RAM load enable.
REQ-016 cpu_hold  output  1  SHALL hold the CPU control unit in clear while a session is active.
REQ-017 done  output  1  SHALL pulse for one cycle when a session completes normally.
REQ-018 words_loaded  output  $clog2(DEPTH)+1  SHALL count the words written in the current/last session.

Function
REQ-019 FSM states IDLE, WAIT_WORD, DRIVE_ADDR, DRIVE_DATA, DONE SHALL be the only states.
REQ-020 IDLE: all strobes 0, cpu_hold=0; start=1 SHALL capture load_len, clear addr and words_loaded, go to DONE if load_len=0, else to WAIT_WORD.
REQ-021 A load_len greater than DEPTH SHALL be saturated to DEPTH at capture.
REQ-022 WAIT_WORD: word_ready=1, cpu_hold=1; word_valid&word_ready SHALL latch word_data and go to DRIVE_ADDR; otherwise stay.
REQ-023 DRIVE_ADDR: bus_oe=1, bus_out = zero-extended addr, mar_le=1, word_ready=0; next DRIVE_DATA.
REQ-024 DRIVE_DATA: bus_oe=1, bus_out = latched word, ram_le=1; addr and words_loaded SHALL increment; go to DONE if words_loaded+1=len, else WAIT_WORD.
REQ-025 DONE: done=1, cpu_hold=1 for this single cycle; next IDLE.
REQ-026 Throughput SHALL be 3 cycles per word with word_valid held high; the first word is accepted 1 cycle after start.
REQ-027 mar_le and ram_le SHALL never be asserted in the same cycle, and neither SHALL be asserted with bus_oe=0.
REQ-028 abort=1 in any non-IDLE state SHALL force IDLE on the next edge with no done pulse; words_loaded retained; abort SHALL take priority over start and word handshake.
REQ-029 start outside IDLE SHALL be ignored.
REQ-030 addr SHALL not wrap; the terminal condition is reached first for every len up to DEPTH.

Reset
REQ-031 reset_n=0 SHALL immediately force IDLE, addr=0, words_loaded=0, latched word=0, and all outputs 0 except bus_out=Z, independent of clock.
REQ-032 Reset mid-session SHALL abandon the session; no partial ram_le SHALL follow reset release.

Structure
REQ-033 A shared package sap_pkg SHALL hold the loader_state_t enum and the DEPTH/ADDR_W/DATA_W default constants.
REQ-034 No sub-module is natural; the tri-state bus driver and counters SHALL stay inside program_loader.

Verification
REQ-035 start, load_len=3, words 0x0008/0x3809/0x300A back-to-back -> MAR writes 0,1,2, RAM writes the three words, done at cycle 10, words_loaded=3.
REQ-036 start, load_len=0 -> done on the next cycle, no mar_le/ram_le, words_loaded=0.
REQ-037 load_len=2, word_valid low for 5 cycles before each word -> word_ready stays high and no bus activity while waiting; correct words at addresses 0,1.
REQ-038 load_len=4, abort asserted in DRIVE_DATA of word 2 -> IDLE next cycle, no done, words_loaded=2, bus_out=Z.
REQ-039 reset_n pulsed low mid DRIVE_ADDR -> outputs cleared asynchronously, bus_out=Z, subsequent start of len=1 works normally.
REQ-040 load_len=20 with DEPTH=16 -> exactly 16 writes at addresses 0..15, done, words_loaded=16.

Source files
------------

// File: rtl/sap_pkg.sv
// Shared SAP definitions: loader FSM state encoding and default geometry constants.
package sap_pkg;

    localparam int unsigned DEPTH_DEFAULT  = 16;
    localparam int unsigned ADDR_W_DEFAULT = 11;
    localparam int unsigned DATA_W_DEFAULT = 16;

    typedef enum logic [2:0] {
        StIdle,
        StWaitWord,
        StDriveAddr,
        StDriveData,
        StDone
    } loader_state_t;

endpackage

// File: rtl/program_loader.sv
// Program loader: takes words from a host handshake and writes them into RAM over the shared
// bus (MAR cycle then RAM cycle per word), holding the CPU in clear while a session runs.
module program_loader
    import sap_pkg::*;
#(
    parameter int unsigned DEPTH  = DEPTH_DEFAULT,
    parameter int unsigned ADDR_W = ADDR_W_DEFAULT,
    parameter int unsigned DATA_W = DATA_W_DEFAULT
) (
    input  logic                       clock,
    input  logic                       reset_n,
    input  logic                       start,
    input  logic [$clog2(DEPTH):0]     load_len,
    input  logic                       abort,
    input  logic                       word_valid,
    input  logic [DATA_W-1:0]          word_data,
    output logic                       word_ready,
    output logic [DATA_W-1:0]          bus_out,
    output logic                       bus_oe,
    output logic                       mar_le,
    output logic                       ram_le,
    output logic                       cpu_hold,
    output logic                       done,
    output logic [$clog2(DEPTH):0]     words_loaded
);

    localparam int unsigned LEN_W = $clog2(DEPTH) + 1;

    loader_state_t     state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [LEN_W-1:0]  cnt_q, cnt_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [DATA_W-1:0] word_q, word_d;
    logic [DATA_W-1:0] bus_drive;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
            addr_q  <= '0;
            cnt_q   <= '0;
            len_q   <= '0;
            word_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            word_q  <= word_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        cnt_d      = cnt_q;
        len_d      = len_q;
        word_d     = word_q;
        word_ready = 1'b0;
        bus_oe     = 1'b0;
        bus_drive  = '0;
        mar_le     = 1'b0;
        ram_le     = 1'b0;
        cpu_hold   = 1'b0;
        done       = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    len_d   = (load_len > LEN_W'(DEPTH)) ? LEN_W'(DEPTH) : load_len;
                    addr_d  = '0;
                    cnt_d   = '0;
                    state_d = (load_len == '0) ? StDone : StWaitWord;
                end
            end
            StWaitWord: begin
                cpu_hold   = 1'b1;
                // Abort wins over the handshake, so withdraw ready rather than drop a word.
                word_ready = !abort;
                if (word_valid && !abort) begin
                    word_d  = word_data;
                    state_d = StDriveAddr;
                end
            end
            StDriveAddr: begin
                cpu_hold  = 1'b1;
                bus_oe    = 1'b1;
                mar_le    = 1'b1;
                bus_drive = DATA_W'(addr_q);
                state_d   = StDriveData;
            end
            StDriveData: begin
                cpu_hold  = 1'b1;
                bus_oe    = 1'b1;
                ram_le    = 1'b1;
                bus_drive = word_q;
                addr_d    = addr_q + 1'b1;
                cnt_d     = cnt_q + 1'b1;
                state_d   = (cnt_d == len_q) ? StDone : StWaitWord;
            end
            StDone: begin
                done     = 1'b1;
                cpu_hold = 1'b1;
                state_d  = StIdle;
            end
            default: state_d = StIdle;
        endcase

        if (abort && (state_q != StIdle)) begin
            state_d = StIdle;
        end
    end

    assign bus_out      = bus_oe ? bus_drive : {DATA_W{1'bz}};
    assign words_loaded = cnt_q;

endmodule
